// File: rtl/branch_pred_unit.sv
// branch_pred_unit: bimodal 2-bit-counter branch predictor with execute-stage branch resolution
// Ports: clk, rst (async, active-high); f_pc -> f_pred_taken (zero-cycle BHT read);
//        ex_valid/ex_instr/ex_pc/ex_pred_taken/br_less/br_equal -> br_taken, redirect (combinational);
//        stat_br_cnt, stat_miss_cnt only when BRANCH_PRED_STATS_EN is defined.
// Parameter BHT_ENTRIES: power of two, 4..1024; index is pc[IDX_W+1:2].
module branch_pred_unit #(
    parameter int BHT_ENTRIES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] f_pc,
    output logic        f_pred_taken,
    input  logic        ex_valid,
    input  logic [31:0] ex_instr,
    input  logic [31:0] ex_pc,
    input  logic        ex_pred_taken,
    input  logic        br_less,
    input  logic        br_equal,
    output logic        br_taken,
    output logic        redirect
`ifdef BRANCH_PRED_STATS_EN
    ,
    output logic [31:0] stat_br_cnt,
    output logic [31:0] stat_miss_cnt
`endif
);
    localparam int IDX_W = $clog2(BHT_ENTRIES);

    logic [1:0]       bht [BHT_ENTRIES];
    logic [IDX_W-1:0] f_idx, ex_idx;
    logic [1:0]       ctr;
    logic [2:0]       f3;
    logic             is_br, is_jmp, cond, upd, unused;

    assign f_idx  = f_pc[IDX_W+1:2];
    assign ex_idx = ex_pc[IDX_W+1:2];
    assign f3     = ex_instr[14:12];
    assign is_br  = ex_instr[6:0] == 7'b1100011;
    assign is_jmp = ex_instr[6:0] == 7'b1101111 || ex_instr[6:0] == 7'b1100111;
    // f3[2] set: BLT/BLTU take on less, BGE/BGEU (f3[0]=1) on not-less
    assign cond = (f3 == 3'b000) ? br_equal : (f3 == 3'b001) ? !br_equal : f3[2] ? (br_less ^ f3[0]) : 1'b0;
    assign br_taken = ex_valid & (is_jmp | (is_br & cond));
    assign redirect = ex_valid & (is_jmp | (is_br & (cond != ex_pred_taken)));
    assign upd = ex_valid & is_br;
    assign ctr = bht[ex_idx];
    assign f_pred_taken = bht[f_idx][1];
    assign unused = ^{f_pc[31:IDX_W+2], f_pc[1:0], ex_pc[31:IDX_W+2], ex_pc[1:0], ex_instr[31:15], ex_instr[11:7]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BHT_ENTRIES; i++) bht[i] <= 2'b01;
        end else if (upd) begin
            bht[ex_idx] <= cond ? (ctr == 2'b11 ? ctr : ctr + 2'd1) : (ctr == 2'b00 ? ctr : ctr - 2'd1);
        end
    end

`ifdef BRANCH_PRED_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_br_cnt   <= '0;
            stat_miss_cnt <= '0;
        end else begin
            if (upd && stat_br_cnt != '1) stat_br_cnt <= stat_br_cnt + 32'd1;
            if (upd && redirect && stat_miss_cnt != '1) stat_miss_cnt <= stat_miss_cnt + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_branch_pred_unit.sv
// tb_branch_pred_unit: directed-vector bench with a behavioural predictor model and per-cycle compare
module tb_branch_pred_unit;
    localparam int N = 64;
    localparam logic [31:0] JAL  = 32'h0000006F;
    localparam logic [31:0] JALR = 32'h00000067;
    localparam logic [31:0] NOP  = 32'h00000013;

    logic        clk = 1'b0, rst = 1'b0;
    logic [31:0] f_pc = '0, ex_instr = 32'h00000013, ex_pc = '0;
    logic        ex_valid = 1'b0, ex_pred_taken = 1'b0, br_less = 1'b0, br_equal = 1'b0;
    logic        f_pred_taken, br_taken, redirect;
`ifdef BRANCH_PRED_STATS_EN
    logic [31:0] stat_br_cnt, stat_miss_cnt;
`endif

    int          n_cmp = 0, n_bad = 0;
    int          mb [N];
    int unsigned m_br = 0, m_miss = 0;

    always #5 clk = ~clk;

    branch_pred_unit #(.BHT_ENTRIES(N)) dut (
        .clk(clk), .rst(rst), .f_pc(f_pc), .f_pred_taken(f_pred_taken),
        .ex_valid(ex_valid), .ex_instr(ex_instr), .ex_pc(ex_pc), .ex_pred_taken(ex_pred_taken),
        .br_less(br_less), .br_equal(br_equal), .br_taken(br_taken), .redirect(redirect)
`ifdef BRANCH_PRED_STATS_EN
        , .stat_br_cnt(stat_br_cnt), .stat_miss_cnt(stat_miss_cnt)
`endif
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit m_cond(input logic [2:0] f, input logic lt, input logic eq);
        case (f)
            3'd0: return eq;
            3'd1: return !eq;
            3'd4, 3'd6: return lt;
            3'd5, 3'd7: return !lt;
            default: return 1'b0;
        endcase
    endfunction

    function automatic int m_idx(input logic [31:0] pc);
        return int'(pc[31:2]) % N;
    endfunction

    function automatic int m_next(input int c, input bit t);
        return t ? (c >= 3 ? 3 : c + 1) : (c <= 0 ? 0 : c - 1);
    endfunction

    function automatic bit m_br_op();
        return ex_instr[6:0] == 7'h63;
    endfunction

    function automatic bit m_jump();
        return ex_instr[6:0] == 7'h6F || ex_instr[6:0] == 7'h67;
    endfunction

    function automatic bit m_taken();
        if (!ex_valid) return 1'b0;
        if (m_jump()) return 1'b1;
        return m_br_op() && m_cond(ex_instr[14:12], br_less, br_equal);
    endfunction

    function automatic bit m_redirect();
        if (!ex_valid) return 1'b0;
        if (m_jump()) return 1'b1;
        return m_br_op() && (m_cond(ex_instr[14:12], br_less, br_equal) != ex_pred_taken);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            foreach (mb[i]) mb[i] <= 1;
            m_br   <= 0;
            m_miss <= 0;
        end else if (ex_valid && m_br_op()) begin
            mb[m_idx(ex_pc)] <= m_next(mb[m_idx(ex_pc)], m_cond(ex_instr[14:12], br_less, br_equal));
            m_br <= m_br + 1;
            if (m_cond(ex_instr[14:12], br_less, br_equal) != ex_pred_taken) m_miss <= m_miss + 1;
        end
    end

    always @(negedge clk) begin
        chk("f_pred", {31'd0, f_pred_taken}, {31'd0, mb[m_idx(f_pc)] >= 2});
        chk("br_taken", {31'd0, br_taken}, {31'd0, m_taken()});
        chk("redirect", {31'd0, redirect}, {31'd0, m_redirect()});
`ifdef BRANCH_PRED_STATS_EN
        chk("stat_br", stat_br_cnt, m_br);
        chk("stat_miss", stat_miss_cnt, m_miss);
`endif
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ex(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                      input logic pt, input logic lt, input logic eq);
        ex_valid = v; ex_instr = ins; ex_pc = pc; ex_pred_taken = pt; br_less = lt; br_equal = eq;
    endtask

    function automatic logic [31:0] br_op(input logic [2:0] f);
        return {17'd0, f, 5'd0, 7'b1100011};
    endfunction

    initial begin
        #2 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        // trained entry, then reset pulse and full sweep
        f_pc = 32'h100;
        ex(1, br_op(3'd0), 32'h100, 0, 0, 1);
        tick(); tick();
        ex(0, NOP, 0, 0, 0, 0);
        #1 chk("pre_reset_trained", {31'd0, f_pred_taken}, 32'd1);
        rst = 1'b1;
        #1 chk("during_reset", {31'd0, f_pred_taken}, 32'd0);
        rst = 1'b0;
        for (int i = 0; i < N; i++) begin
            tick();
            f_pc = i << 2;
            #1 chk("sweep", {31'd0, f_pred_taken}, 32'd0);
        end
        // condition decode
        tick(); ex(1, br_op(3'd0), 32'h200, 0, 0, 1);
        #1 chk("beq_taken", {31'd0, br_taken}, 32'd1); chk("beq_redirect", {31'd0, redirect}, 32'd1);
        tick(); ex(1, br_op(3'd5), 32'h200, 0, 1, 0);
        #1 chk("bge_taken", {31'd0, br_taken}, 32'd0); chk("bge_redirect", {31'd0, redirect}, 32'd0);
        tick(); ex(1, br_op(3'd1), 32'h204, 1, 0, 1);
        #1 chk("bne_taken", {31'd0, br_taken}, 32'd0); chk("bne_redirect", {31'd0, redirect}, 32'd1);
        tick(); ex(1, br_op(3'd6), 32'h208, 1, 1, 0);
        #1 chk("bltu_taken", {31'd0, br_taken}, 32'd1); chk("bltu_redirect", {31'd0, redirect}, 32'd0);
        tick(); ex(1, br_op(3'd2), 32'h20C, 1, 1, 1);
        #1 chk("f3_010_taken", {31'd0, br_taken}, 32'd0); chk("f3_010_redirect", {31'd0, redirect}, 32'd1);
        tick(); ex(0, br_op(3'd0), 32'h200, 0, 0, 1);
        #1 chk("invalid_taken", {31'd0, br_taken}, 32'd0); chk("invalid_redirect", {31'd0, redirect}, 32'd0);
        tick(); ex(0, NOP, 0, 0, 0, 0);
        // training walk at 0x40
        f_pc = 32'h40;
        ex(1, br_op(3'd0), 32'h40, 0, 0, 1);
        #1 chk("train_e0", {31'd0, f_pred_taken}, 32'd0);
        tick(); chk("train_e1", {31'd0, f_pred_taken}, 32'd1);
        tick(); chk("train_e2", {31'd0, f_pred_taken}, 32'd1);
        tick(); chk("train_sat", {31'd0, f_pred_taken}, 32'd1);
        ex(1, br_op(3'd0), 32'h40, 0, 0, 0);
        tick(); chk("untrain_1", {31'd0, f_pred_taken}, 32'd1);
        tick(); chk("untrain_2", {31'd0, f_pred_taken}, 32'd0);
        tick(); chk("untrain_3", {31'd0, f_pred_taken}, 32'd0);
        tick(); chk("untrain_sat", {31'd0, f_pred_taken}, 32'd0);
        ex(1, br_op(3'd0), 32'h40, 0, 0, 1);
        tick(); chk("no_wrap_00", {31'd0, f_pred_taken}, 32'd0);
        // aliasing: 0x140 shares the 0x40 entry
        tick(); chk("alias_t1", {31'd0, f_pred_taken}, 32'd1);
        tick(); chk("alias_t2", {31'd0, f_pred_taken}, 32'd1);
        ex(1, br_op(3'd0), 32'h140, 0, 0, 0);
        tick(); chk("alias_dec1", {31'd0, f_pred_taken}, 32'd1);
        tick(); chk("alias_dec2", {31'd0, f_pred_taken}, 32'd0);
        // same-cycle read and update, no bypass
        ex(0, NOP, 0, 0, 0, 0);
        tick();
        f_pc = 32'h80;
        ex(1, br_op(3'd0), 32'h80, 0, 0, 1);
        #1 chk("same_cycle_old", {31'd0, f_pred_taken}, 32'd0);
        tick(); chk("same_cycle_next", {31'd0, f_pred_taken}, 32'd1);
        // jumps and non-branches leave the table alone
        f_pc = 32'hC0;
        ex(1, JAL, 32'hC0, 1, 0, 0);
        #1 chk("jal_taken", {31'd0, br_taken}, 32'd1); chk("jal_redirect", {31'd0, redirect}, 32'd1);
        tick(); ex(1, JALR, 32'hC0, 0, 0, 1);
        #1 chk("jalr_redirect", {31'd0, redirect}, 32'd1);
        tick(); ex(0, br_op(3'd0), 32'hC0, 0, 0, 1);
        tick(); ex(1, NOP, 32'hC0, 0, 1, 1);
        #1 chk("nop_taken", {31'd0, br_taken}, 32'd0); chk("nop_redirect", {31'd0, redirect}, 32'd0);
        tick(); chk("jump_bht_unchanged", {31'd0, f_pred_taken}, 32'd0);
`ifdef BRANCH_PRED_STATS_EN
        tick(); rst = 1'b1;
        #1 chk("stat_br_reset", stat_br_cnt, 32'd0); chk("stat_miss_reset", stat_miss_cnt, 32'd0);
        rst = 1'b0;
        tick(); ex(1, br_op(3'd0), 32'h300, 0, 0, 1);
        tick(); ex(1, br_op(3'd0), 32'h300, 1, 0, 1);
        tick(); ex(1, br_op(3'd0), 32'h300, 0, 0, 0);
        tick(); ex(1, br_op(3'd0), 32'h300, 1, 0, 0);
        tick(); ex(1, br_op(3'd0), 32'h300, 1, 0, 1);
        tick(); ex(1, JAL, 32'h300, 0, 0, 0);
        tick(); ex(0, NOP, 0, 0, 0, 0);
        #1 chk("stat_br_5", stat_br_cnt, 32'd5); chk("stat_miss_2", stat_miss_cnt, 32'd2);
        rst = 1'b1;
        #1 chk("stat_br_midrst", stat_br_cnt, 32'd0); chk("stat_miss_midrst", stat_miss_cnt, 32'd0);
        rst = 1'b0;
`endif
        // update edge under reset is dropped; first edge after release updates
        tick();
        f_pc = 32'h380;
        ex(1, br_op(3'd0), 32'h380, 0, 0, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1 chk("rst_edge_ignored", {31'd0, f_pred_taken}, 32'd0);
        tick(); chk("first_edge_after_rst", {31'd0, f_pred_taken}, 32'd1);
        ex(0, NOP, 0, 0, 0, 0);
        tick(); tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/branch_pred_unit.md
BRANCH_PRED_UNIT -- requirements
Module: branch_pred_unit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, named clk and rst.
REQ-002 Parameter BHT_ENTRIES, default 64, SHALL set the number of branch history table entries; only powers of two from 4 to 1024 are legal.
REQ-003 Derived IDX_W = log2(BHT_ENTRIES) SHALL be the table index width.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  asynchronous active-high reset.
REQ-006 f_pc  in  32  fetch-stage PC to predict.
REQ-007 f_pred_taken  out  1  prediction for f_pc; 1 = taken.
REQ-008 ex_valid  in  1  execute-stage instruction is valid and not squashed.
REQ-009 ex_instr  in  32  execute-stage instruction word.
REQ-010 ex_pc  in  32  execute-stage PC.
REQ-011 ex_pred_taken  in  1  prediction that travelled with ex_instr through the pipeline.
REQ-012 br_less  in  1  comparator less-than result, already signed or unsigned as funct3 requires.
REQ-013 br_equal  in  1  comparator equality result.
REQ-014 br_taken  out  1  resolved branch or jump outcome.
REQ-015 redirect  out  1  execute stage must flush younger instructions and load the correct PC.
REQ-016 stat_br_cnt  out  32  resolved conditional-branch count; exists only with the config macro.
REQ-017 stat_miss_cnt  out  32  mispredict count; exists only with the config macro.

Function
REQ-018 The BHT SHALL hold BHT_ENTRIES 2-bit saturating counters: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
REQ-019 The index SHALL be pc[IDX_W+1:2] for both the fetch read and the execute update.
REQ-020 f_pred_taken SHALL be combinational from f_pc and equal bit 1 of the indexed counter (zero-cycle read).
REQ-021 A conditional branch is ex_instr[6:0] = 1100011; ex_instr[14:12] selects the condition:
- 000 BEQ: br_equal
- 001 BNE: !br_equal
- 100 BLT, 110 BLTU: br_less
- 101 BGE, 111 BGEU: !br_less
- 010, 011: not taken
REQ-022 JAL (1101111) and JALR (1100111) SHALL give br_taken = 1; every other opcode SHALL give br_taken = 0.
REQ-023 br_taken and redirect SHALL be combinational from the ex_* inputs, with zero-cycle latency.
REQ-024 For a conditional branch, redirect = ex_valid & (br_taken != ex_pred_taken).
REQ-025 For JAL or JALR, redirect = ex_valid.
REQ-026 For any other opcode, redirect = 0.
REQ-027 When ex_valid = 0, br_taken and redirect SHALL be 0 regardless of the other inputs.
REQ-028 On a rising clk edge with ex_valid = 1 and a conditional branch, the counter at the ex_pc index SHALL:
- increment if taken, saturating at 11;
- decrement if not taken, saturating at 00.
REQ-029 Jumps, non-branches and invalid cycles SHALL leave the BHT unchanged.
REQ-030 If the fetch read and execute update hit the same index in the same cycle, f_pred_taken SHALL show the pre-update value; no bypass.
REQ-031 An updated counter SHALL become visible to f_pred_taken in the cycle after the update edge.

Reset
REQ-032 Asserting rst SHALL immediately, without a clock edge, set every BHT counter to 01 and every statistics counter to 0.
REQ-033 During reset, f_pred_taken SHALL read 0.
REQ-034 br_taken and redirect SHALL stay purely combinational; reset does not gate them.
REQ-035 An update edge coincident with rst asserted SHALL be ignored.
REQ-036 The first edge after rst deasserts SHALL update normally.

Configuration
REQ-037 Macro BRANCH_PRED_STATS_EN, when defined, SHALL compile in stat_br_cnt and stat_miss_cnt.
REQ-038 With BRANCH_PRED_STATS_EN defined:
- stat_br_cnt increments on each REQ-028 update edge;
- stat_miss_cnt increments on each edge where a conditional branch has redirect = 1;
- both saturate at 0xFFFFFFFF.
REQ-039 With BRANCH_PRED_STATS_EN undefined, both ports and their registers SHALL be absent, and the remaining behaviour SHALL be identical.

Verification
REQ-040 Reset check: pulse rst, then sweep f_pc from 0x0 to 0xFC -> f_pred_taken = 0 for every entry.
REQ-041 Condition decode, with ex_valid = 1 and ex_pred_taken = 0:
- BEQ with br_equal = 1 -> br_taken = 1, redirect = 1;
- BGE with br_less = 1 -> br_taken = 0, redirect = 0.
REQ-042 Training: drive three taken BEQ at ex_pc = 0x40 on consecutive edges -> f_pred_taken at f_pc = 0x40 reads 0, 1, 1 after edges 0/1/2; counter saturates at 11.
- Then drive three not-taken BEQ at 0x40 -> the counter walks down to 00.
REQ-043 Collision: with BHT_ENTRIES = 64, train 0x40 to taken, then update 0x140 as not taken -> the shared index decrements and f_pred_taken at 0x40 follows.
REQ-044 Same-cycle read/write: f_pc = ex_pc = 0x80 with counter 01 and a taken update -> f_pred_taken = 0 that cycle and 1 the next.
REQ-045 Jumps and stats:
- JAL with ex_pred_taken = 1 -> redirect = 1 and BHT unchanged;
- with the macro defined, 5 branches including 2 mispredicts -> stat_br_cnt = 5, stat_miss_cnt = 2;
- asserting rst mid-sequence -> both counters read 0 immediately.
